animation_sequencer: RTL
========================

ANIMATION_SEQUENCER -- requirements
Module: animation_sequencer

Interface
REQ-001 Parameter TICK_RELOAD, 20'd833334, frame-tick down-counter reload value; tick period is TICK_RELOAD+1 clk cycles.
REQ-002 Parameter FRAMES_PER_STEP, 4'd15, frame down-counter reload value; one animation step per FRAMES_PER_STEP+1 frame ticks.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  level; 1 runs the animation, 0 returns the block to idle at the next step boundary.
REQ-006 plot_done  input  1  one-cycle pulse from the plotter datapath: current plot pass complete.
REQ-007 plot_req  output  1  level; requests one plot pass; held until plot_done is sampled.
REQ-008 erase  output  1  colour select for the plotter; 1 = background colour, 0 = object colour; valid whenever plot_req=1.
REQ-009 update_pos  output  1  one-cycle pulse; object-position registers advance one step.
REQ-010 frame_tick  output  1  one-cycle pulse each time the tick counter wraps.
REQ-011 busy  output  1  1 in any state other than IDLE.
REQ-012 overrun  output  1  sticky flag; a step fell due while the previous step was still in progress.

Function
REQ-013 The tick counter SHALL be a 20-bit down-counter that decrements every cycle, free-running regardless of state.
REQ-014 When the tick counter equals 0 it SHALL reload TICK_RELOAD and frame_tick SHALL be 1 in that cycle only.
REQ-015 The frame counter SHALL be a 4-bit down-counter held at FRAMES_PER_STEP in IDLE and decremented on frame_tick in all other states.
REQ-016 step_due SHALL be frame_tick AND frame counter==0; in that cycle the frame counter SHALL reload FRAMES_PER_STEP instead of decrementing (no wrap to 4'hF by underflow).
REQ-017 The FSM states SHALL be IDLE, WAIT, ERASE, UPDATE, DRAW.
REQ-018 IDLE -> WAIT when enable=1; otherwise remain.
REQ-019 WAIT -> ERASE on step_due; WAIT -> IDLE when enable=0 and step_due=0.
REQ-020 ERASE: plot_req=1, erase=1; -> UPDATE on the cycle plot_done=1 is sampled.
REQ-021 UPDATE: update_pos=1 for exactly this one cycle; unconditionally -> DRAW.
REQ-022 DRAW: plot_req=1, erase=0; on plot_done=1 -> WAIT if enable=1, else IDLE.
REQ-023 plot_req SHALL be registered (Moore): first 1 the cycle after entering ERASE/DRAW, first 0 the cycle after plot_done is sampled.
REQ-024 plot_done while not in ERASE or DRAW SHALL be ignored.
REQ-025 enable=0 during ERASE/UPDATE/DRAW SHALL NOT abort the step; the step completes, then IDLE.
REQ-026 step_due in ERASE, UPDATE or DRAW SHALL set overrun and the due step SHALL be dropped, not queued.
REQ-027 overrun SHALL clear only on reset.
REQ-028 erase SHALL be 0 whenever plot_req=0.

Reset
REQ-029 On reset: state IDLE, tick counter=TICK_RELOAD, frame counter=FRAMES_PER_STEP, plot_req=0, erase=0, update_pos=0, frame_tick=0, busy=0, overrun=0.
REQ-030 Reset asserted mid-step SHALL abandon the step with no further update_pos pulse; plot_req drops the following cycle.

Structure
REQ-031 A shared package SHALL hold the state enumeration and the default TICK_RELOAD/FRAMES_PER_STEP constants.
REQ-032 One sub-module, reload_down_counter (parameterised width/reload, enable input, wrap pulse output), SHALL implement both counters.

Verification (TICK_RELOAD=3, FRAMES_PER_STEP=1 unless stated)
REQ-033 Reset then idle 20 cycles -> frame_tick every 4 cycles, plot_req=0, busy=0, frame counter held at 1.
REQ-034 enable=1, plotter answers plot_done 2 cycles after plot_req rises -> per step: ERASE pass (erase=1), one update_pos pulse, DRAW pass (erase=0); steps 8 cycles apart.
REQ-035 enable dropped during DRAW -> DRAW completes on plot_done, state IDLE, no further plot_req.
REQ-036 Plotter withholds plot_done 12 cycles in ERASE -> plot_req held high, overrun=1, dropped step produces no extra update_pos.
REQ-037 reset pulsed during ERASE -> next cycle plot_req=0, busy=0, overrun=0, counters at reload values.
REQ-038 Defaults (833334, 15) -> frame_tick period 833335 cycles; first step_due 16 ticks after enable.

Source files
------------

// File: rtl/animation_sequencer_pkg.sv
// Shared types and default timing constants for the animation sequencer.
package animation_sequencer_pkg;

  localparam int TICK_W  = 20;
  localparam int FRAME_W = 4;

  localparam logic [TICK_W-1:0]  TICK_RELOAD_DEFAULT     = 20'd833334;
  localparam logic [FRAME_W-1:0] FRAMES_PER_STEP_DEFAULT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ERASE,
    S_UPDATE,
    S_DRAW
  } state_t;

endpackage

// File: rtl/animation_sequencer_if.sv
// Plotter handshake, control and observation signals of the animation sequencer.
// Handshake: plot_req is a level held by the sequencer until a one-cycle plot_done
// is sampled with plot_req high; plot_done at any other time is ignored.
interface animation_sequencer_if;
  import animation_sequencer_pkg::*;

  logic                enable;
  logic                plot_done;
  logic                plot_req;
  logic                erase;
  logic                update_pos;
  logic                frame_tick;
  logic                busy;
  logic                overrun;
  state_t              state;
  logic [TICK_W-1:0]   tick_count;
  logic [FRAME_W-1:0]  frame_count;

  modport master (
    input  enable, plot_done,
    output plot_req, erase, update_pos, frame_tick, busy, overrun,
           state, tick_count, frame_count
  );

  modport slave (
    output enable, plot_done,
    input  plot_req, erase, update_pos, frame_tick, busy, overrun,
           state, tick_count, frame_count
  );
endinterface

// File: rtl/reload_down_counter.sv
// Down-counter that reloads on reaching zero and flags that cycle with wrap;
// hold pins it at the reload value and suppresses wrap.
module reload_down_counter #(
  parameter int unsigned      WIDTH  = 4,
  parameter logic [WIDTH-1:0] RELOAD = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             hold,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = 1;

  assign wrap = en && !hold && (count == '0);

  always_ff @(posedge clk) begin
    if (reset || hold) begin
      count <= RELOAD;
    end else if (en) begin
      count <= (count == '0) ? RELOAD : count - ONE;
    end
  end

endmodule

// File: rtl/animation_sequencer.sv
// Paces erase / update / redraw passes of an animated object from a free-running
// frame tick and hands each plot pass to an external plotter.
module animation_sequencer
  import animation_sequencer_pkg::*;
#(
  parameter logic [TICK_W-1:0]  TICK_RELOAD     = TICK_RELOAD_DEFAULT,
  parameter logic [FRAME_W-1:0] FRAMES_PER_STEP = FRAMES_PER_STEP_DEFAULT
) (
  input logic                   clk,
  input logic                   reset,
  animation_sequencer_if.master bus
);

  state_t             state;
  logic               frame_tick;
  logic               step_due;
  logic [TICK_W-1:0]  tick_count;
  logic [FRAME_W-1:0] frame_count;
  logic               in_step;

  reload_down_counter #(.WIDTH(TICK_W), .RELOAD(TICK_RELOAD)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .hold  (1'b0),
    .count (tick_count),
    .wrap  (frame_tick)
  );

  // Frame counter wraps straight to the reload value, so its wrap is the step strobe.
  reload_down_counter #(.WIDTH(FRAME_W), .RELOAD(FRAMES_PER_STEP)) u_frame (
    .clk   (clk),
    .reset (reset),
    .en    (frame_tick),
    .hold  (state == S_IDLE),
    .count (frame_count),
    .wrap  (step_due)
  );

  assign in_step = (state == S_ERASE) || (state == S_UPDATE) || (state == S_DRAW);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      bus.plot_req   <= 1'b0;
      bus.erase      <= 1'b0;
      bus.update_pos <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.update_pos <= 1'b0;
      // A step falling due mid-step is dropped; only the flag remembers it.
      if (step_due && in_step) bus.overrun <= 1'b1;
      case (state)
        S_IDLE: if (bus.enable) state <= S_WAIT;
        S_WAIT: begin
          if (step_due) begin
            state        <= S_ERASE;
            bus.plot_req <= 1'b1;
            bus.erase    <= 1'b1;
          end else if (!bus.enable) begin
            state <= S_IDLE;
          end
        end
        S_ERASE: begin
          if (bus.plot_done) begin
            state          <= S_UPDATE;
            bus.plot_req   <= 1'b0;
            bus.erase      <= 1'b0;
            bus.update_pos <= 1'b1;
          end
        end
        S_UPDATE: begin
          state        <= S_DRAW;
          bus.plot_req <= 1'b1;
          bus.erase    <= 1'b0;
        end
        S_DRAW: begin
          if (bus.plot_done) begin
            state        <= bus.enable ? S_WAIT : S_IDLE;
            bus.plot_req <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          bus.plot_req <= 1'b0;
          bus.erase    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.frame_tick  = frame_tick;
  assign bus.state       = state;
  assign bus.tick_count  = tick_count;
  assign bus.frame_count = frame_count;

endmodule
